// File: rtl/spi_master.sv
// SPI master: one word per rising edge of i_SPI_Send_Sync, configurable CPOL, sample edge,
// word width, SCLK half-period and optional MISO deglitch filter.
module spi_master #(
    parameter logic IDLE_VALUE_for_Clk    = 1'b0,
    parameter logic IDLE_VALUE_for_MOSI   = 1'b0,
    parameter logic DATA_VALID_at_FALLING = 1'b0,
    parameter int   Tran_width            = 32,
    parameter logic DE_GLITCH_Enable      = 1'b0,
    parameter int   CLK_HALF              = 5
) (
    input  logic                  c_clk_100m,
    input  logic                  i_rst,
    input  logic                  i_SPI_Send_Sync,
    input  logic [Tran_width-1:0] i_SPI_Send_Data,
    output logic                  o_SPI_Send_Over_ack,
    output logic                  o_SPI_Receive_Sync,
    output logic [Tran_width-1:0] o_SPI_Receive_Data,
    output logic                  o_SPI_Clk,
    output logic                  o_SPI_SS,
    output logic                  o_SPI_MOSI,
    input  logic                  i_SPI_MISO,
    output logic [2:0]            fsm_state
);

    localparam int CW = $clog2(CLK_HALF + 1);
    localparam int EW = $clog2(2 * Tran_width + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * Tran_width);
    // The first SCLK edge leaves the idle level; it samples when its direction matches the sample edge.
    localparam logic FIRST_IS_SAMPLE = (IDLE_VALUE_for_Clk == DATA_VALID_at_FALLING);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        XFER  = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CW-1:0]         cnt;
    logic [EW-1:0]         edge_cnt;
    logic [EW-1:0]         edge_num;
    logic                  sync_prev;
    logic                  start;
    logic                  half_done;
    logic                  do_edge;
    logic                  is_sample;
    logic                  last_edge;
    logic [Tran_width-1:0] tx_shift;
    logic [Tran_width-1:0] rx_shift;
    logic [Tran_width-1:0] rx_next;
    logic                  miso_s;

    assign start     = i_SPI_Send_Sync & ~sync_prev;
    assign fsm_state = state;

    always_ff @(posedge c_clk_100m) begin
        if (i_rst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        do_edge    = 1'b0;
        half_done  = (cnt == HALF_LAST);
        edge_num   = edge_cnt + 1'b1;
        is_sample  = (edge_num[0] == FIRST_IS_SAMPLE);
        last_edge  = (edge_num == EDGE_LAST);
        rx_next    = rx_shift << 1;
        rx_next[0] = miso_s;
        case (state)
            IDLE:  if (start) next_state = LEAD;
            LEAD: begin
                if (half_done) begin
                    next_state = XFER;
                    do_edge    = 1'b1;
                end
            end
            // Each XFER half-period opens with an edge; the final half-period is edge-free.
            XFER: begin
                if (half_done) begin
                    if (edge_cnt == EDGE_LAST) next_state = TRAIL;
                    else                       do_edge    = 1'b1;
                end
            end
            TRAIL: if (half_done) next_state = GAP;
            GAP:   if (half_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge c_clk_100m) begin
        if (i_rst) begin
            sync_prev           <= 1'b0;
            cnt                 <= '0;
            edge_cnt            <= '0;
            tx_shift            <= '0;
            rx_shift            <= '0;
            o_SPI_Clk           <= IDLE_VALUE_for_Clk;
            o_SPI_SS            <= 1'b1;
            o_SPI_MOSI          <= IDLE_VALUE_for_MOSI;
            o_SPI_Send_Over_ack <= 1'b0;
            o_SPI_Receive_Sync  <= 1'b0;
            o_SPI_Receive_Data  <= '0;
        end else begin
            sync_prev           <= i_SPI_Send_Sync;
            o_SPI_Send_Over_ack <= 1'b0;
            o_SPI_Receive_Sync  <= 1'b0;
            if (state == IDLE || half_done) cnt <= '0;
            else                            cnt <= cnt + 1'b1;

            if (state == IDLE && start) begin
                o_SPI_SS  <= 1'b0;
                o_SPI_Clk <= IDLE_VALUE_for_Clk;
                edge_cnt  <= '0;
                rx_shift  <= '0;
                if (FIRST_IS_SAMPLE) begin
                    o_SPI_MOSI <= i_SPI_Send_Data[Tran_width-1];
                    tx_shift   <= i_SPI_Send_Data << 1;
                end else begin
                    tx_shift   <= i_SPI_Send_Data;
                end
            end

            if (do_edge) begin
                o_SPI_Clk <= ~o_SPI_Clk;
                edge_cnt  <= edge_num;
                if (is_sample) begin
                    rx_shift <= rx_next;
                end else if (!last_edge) begin
                    // A trailing launch edge keeps the LSB on the line instead of shifting.
                    o_SPI_MOSI <= tx_shift[Tran_width-1];
                    tx_shift   <= tx_shift << 1;
                end
            end

            if (state == TRAIL && half_done) begin
                o_SPI_SS            <= 1'b1;
                o_SPI_MOSI          <= IDLE_VALUE_for_MOSI;
                o_SPI_Receive_Data  <= rx_shift;
                o_SPI_Receive_Sync  <= 1'b1;
                o_SPI_Send_Over_ack <= 1'b1;
            end
        end
    end

    generate
        if (DE_GLITCH_Enable) begin : g_deglitch
            logic [1:0] sync_ff;
            logic [1:0] hist;
            always_ff @(posedge c_clk_100m) begin
                if (i_rst) begin
                    sync_ff <= '0;
                    hist    <= '0;
                end else begin
                    sync_ff <= {sync_ff[0], i_SPI_MISO};
                    hist    <= {hist[0], sync_ff[1]};
                end
            end
            // Majority over the synchronizer output and its two predecessors.
            assign miso_s = (sync_ff[1] & hist[0]) | (sync_ff[1] & hist[1]) | (hist[0] & hist[1]);
        end else begin : g_direct
            assign miso_s = i_SPI_MISO;
        end
    endgenerate

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: four instances cover default mode, falling-edge sampling,
// inverted idle levels and the MISO deglitch filter.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sync = 4'b0000;
    logic [31:0] sdata0 = '0;
    logic [23:0] sdata1 = '0;
    logic [7:0]  sdata2 = '0;
    logic [7:0]  sdata3 = '0;
    logic        miso1_val = 1'b0;
    logic        dg_loop = 1'b0;
    logic        dg_glitch = 1'b0;

    wire  [3:0]  ack, rsync, sclk, ss, mosi, miso;
    wire  [31:0] rdata0;
    wire  [23:0] rdata1;
    wire  [7:0]  rdata2, rdata3;
    wire  [2:0]  st0, st1, st2, st3;

    int          assert_cnt = 0;
    int          fail_cnt = 0;
    int          pulses, ss_low, acks, rsyncs, both, unstable;
    int          tot_acks, tot_ss;
    logic [31:0] bits;

    assign miso[0] = mosi[0];
    assign miso[1] = miso1_val;
    assign miso[2] = mosi[2];
    assign miso[3] = dg_loop ? mosi[3] : dg_glitch;

    always #5 clk = ~clk;

    spi_master u_dut0 (
        .c_clk_100m(clk), .i_rst(rst), .i_SPI_Send_Sync(sync[0]), .i_SPI_Send_Data(sdata0),
        .o_SPI_Send_Over_ack(ack[0]), .o_SPI_Receive_Sync(rsync[0]), .o_SPI_Receive_Data(rdata0),
        .o_SPI_Clk(sclk[0]), .o_SPI_SS(ss[0]), .o_SPI_MOSI(mosi[0]), .i_SPI_MISO(miso[0]),
        .fsm_state(st0)
    );

    spi_master #(.DATA_VALID_at_FALLING(1'b1), .Tran_width(24)) u_dut1 (
        .c_clk_100m(clk), .i_rst(rst), .i_SPI_Send_Sync(sync[1]), .i_SPI_Send_Data(sdata1),
        .o_SPI_Send_Over_ack(ack[1]), .o_SPI_Receive_Sync(rsync[1]), .o_SPI_Receive_Data(rdata1),
        .o_SPI_Clk(sclk[1]), .o_SPI_SS(ss[1]), .o_SPI_MOSI(mosi[1]), .i_SPI_MISO(miso[1]),
        .fsm_state(st1)
    );

    spi_master #(.IDLE_VALUE_for_Clk(1'b1), .IDLE_VALUE_for_MOSI(1'b1), .Tran_width(8),
                 .CLK_HALF(2)) u_dut2 (
        .c_clk_100m(clk), .i_rst(rst), .i_SPI_Send_Sync(sync[2]), .i_SPI_Send_Data(sdata2),
        .o_SPI_Send_Over_ack(ack[2]), .o_SPI_Receive_Sync(rsync[2]), .o_SPI_Receive_Data(rdata2),
        .o_SPI_Clk(sclk[2]), .o_SPI_SS(ss[2]), .o_SPI_MOSI(mosi[2]), .i_SPI_MISO(miso[2]),
        .fsm_state(st2)
    );

    spi_master #(.DE_GLITCH_Enable(1'b1), .Tran_width(8), .CLK_HALF(5)) u_dut3 (
        .c_clk_100m(clk), .i_rst(rst), .i_SPI_Send_Sync(sync[3]), .i_SPI_Send_Data(sdata3),
        .o_SPI_Send_Over_ack(ack[3]), .o_SPI_Receive_Sync(rsync[3]), .o_SPI_Receive_Data(rdata3),
        .o_SPI_Clk(sclk[3]), .o_SPI_SS(ss[3]), .o_SPI_MOSI(mosi[3]), .i_SPI_MISO(miso[3]),
        .fsm_state(st3)
    );

    // Observe instance d for n cycles at falling clk edges; MOSI is captured at each sample edge.
    task automatic watch(input int d, input int n, input bit samp_rise);
        logic ps, pm, rose, fell;
        pulses = 0; ss_low = 0; acks = 0; rsyncs = 0; both = 0; unstable = 0; bits = '0;
        ps = sclk[d];
        pm = mosi[d];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rose = !ps && sclk[d];
            fell = ps && !sclk[d];
            if (rose) pulses++;
            if (samp_rise ? rose : fell) begin
                bits = {bits[30:0], mosi[d]};
                if (mosi[d] !== pm) unstable++;
            end
            if (!ss[d]) ss_low++;
            if (ack[d]) acks++;
            if (rsync[d]) rsyncs++;
            if (ack[d] && rsync[d]) both++;
            ps = sclk[d];
            pm = mosi[d];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        assert_cnt++; if (ss !== 4'b1111) begin fail_cnt++; $display("FAIL reset_ss: got %b expected 1111", ss); end
        assert_cnt++; if (sclk !== 4'b0100) begin fail_cnt++; $display("FAIL reset_sclk: got %b expected 0100", sclk); end
        assert_cnt++; if (mosi !== 4'b0100) begin fail_cnt++; $display("FAIL reset_mosi: got %b expected 0100", mosi); end
        assert_cnt++; if ((ack | rsync) !== 4'b0000) begin fail_cnt++; $display("FAIL reset_pulses: got %b/%b expected 0", ack, rsync); end
        assert_cnt++; if (rdata0 !== 32'h0) begin fail_cnt++; $display("FAIL reset_rdata: got %h expected 0", rdata0); end
        assert_cnt++; if ({st0, st1, st2, st3} !== 12'h000) begin fail_cnt++; $display("FAIL reset_state: got %h expected 000", {st0, st1, st2, st3}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        sdata0 = 32'hFFFF_A5A5;
        sync[0] = 1'b1;
        watch(0, 400, 1'b1);
        sync[0] = 1'b0;
        assert_cnt++; if (pulses !== 32) begin fail_cnt++; $display("FAIL basic_pulses: got %0d expected 32", pulses); end
        assert_cnt++; if (bits !== 32'hFFFF_A5A5) begin fail_cnt++; $display("FAIL basic_mosi: got %h expected ffffa5a5", bits); end
        assert_cnt++; if (ss_low !== 330) begin fail_cnt++; $display("FAIL basic_ss_low: got %0d expected 330", ss_low); end
        assert_cnt++; if (rdata0 !== 32'hFFFF_A5A5) begin fail_cnt++; $display("FAIL basic_rdata: got %h expected ffffa5a5", rdata0); end
        assert_cnt++; if (acks !== 1 || rsyncs !== 1 || both !== 1) begin fail_cnt++; $display("FAIL basic_pulses_once: got ack=%0d rsync=%0d same=%0d expected 1/1/1", acks, rsyncs, both); end
        assert_cnt++; if (unstable !== 0) begin fail_cnt++; $display("FAIL basic_mosi_stable: got %0d changes expected 0", unstable); end
    endtask

    task automatic test_sample_falling();
        sdata1 = 24'hA5A5A5;
        miso1_val = 1'b0;
        sync[1] = 1'b1;
        fork
            watch(1, 300, 1'b0);
            begin
                repeat (3) @(negedge clk);
                sdata1 = 24'h000000;
            end
        join
        sync[1] = 1'b0;
        assert_cnt++; if (pulses !== 24) begin fail_cnt++; $display("FAIL fall_pulses: got %0d expected 24", pulses); end
        assert_cnt++; if (bits[23:0] !== 24'hA5A5A5) begin fail_cnt++; $display("FAIL fall_mosi: got %h expected a5a5a5", bits[23:0]); end
        assert_cnt++; if (ss_low !== 250) begin fail_cnt++; $display("FAIL fall_ss_low: got %0d expected 250", ss_low); end
        assert_cnt++; if (unstable !== 0) begin fail_cnt++; $display("FAIL fall_mosi_stable: got %0d changes expected 0", unstable); end
        assert_cnt++; if (rdata1 !== 24'h000000 || acks !== 1) begin fail_cnt++; $display("FAIL fall_rdata0: got %h ack=%0d expected 000000 ack=1", rdata1, acks); end
        sdata1 = 24'h0F0F0F;
        miso1_val = 1'b1;
        repeat (5) @(negedge clk);
        sync[1] = 1'b1;
        watch(1, 300, 1'b0);
        sync[1] = 1'b0;
        assert_cnt++; if (bits[23:0] !== 24'h0F0F0F) begin fail_cnt++; $display("FAIL fall_mosi2: got %h expected 0f0f0f", bits[23:0]); end
        assert_cnt++; if (rdata1 !== 24'hFFFFFF) begin fail_cnt++; $display("FAIL fall_rdata1: got %h expected ffffff", rdata1); end
    endtask

    task automatic test_idle_levels();
        sdata2 = 8'h3C;
        sync[2] = 1'b1;
        watch(2, 60, 1'b1);
        sync[2] = 1'b0;
        assert_cnt++; if (pulses !== 8) begin fail_cnt++; $display("FAIL idle_pulses: got %0d expected 8", pulses); end
        assert_cnt++; if (bits[7:0] !== 8'h3C) begin fail_cnt++; $display("FAIL idle_mosi: got %h expected 3c", bits[7:0]); end
        assert_cnt++; if (ss_low !== 36) begin fail_cnt++; $display("FAIL idle_ss_low: got %0d expected 36", ss_low); end
        assert_cnt++; if (rdata2 !== 8'h3C || acks !== 1) begin fail_cnt++; $display("FAIL idle_rdata: got %h ack=%0d expected 3c ack=1", rdata2, acks); end
        assert_cnt++; if (sclk[2] !== 1'b1 || mosi[2] !== 1'b1) begin fail_cnt++; $display("FAIL idle_after: got sclk=%b mosi=%b expected 1/1", sclk[2], mosi[2]); end
    endtask

    task automatic test_deglitch();
        dg_loop = 1'b1;
        sdata3 = 8'h96;
        sync[3] = 1'b1;
        watch(3, 120, 1'b1);
        sync[3] = 1'b0;
        assert_cnt++; if (rdata3 !== 8'h96 || acks !== 1) begin fail_cnt++; $display("FAIL dg_loop_rdata: got %h ack=%0d expected 96 ack=1", rdata3, acks); end
        assert_cnt++; if (ss_low !== 90) begin fail_cnt++; $display("FAIL dg_ss_low: got %0d expected 90", ss_low); end
        dg_loop = 1'b0;
        dg_glitch = 1'b0;
        sdata3 = 8'hFF;
        repeat (5) @(negedge clk);
        sync[3] = 1'b1;
        acks = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            dg_glitch = ((i % 7) == 3);
            if (ack[3]) acks++;
        end
        dg_glitch = 1'b0;
        sync[3] = 1'b0;
        assert_cnt++; if (rdata3 !== 8'h00 || acks !== 1) begin fail_cnt++; $display("FAIL dg_glitch_rdata: got %h ack=%0d expected 00 ack=1", rdata3, acks); end
    endtask

    task automatic test_back_to_back();
        sync[0] = 1'b0;
        repeat (10) @(negedge clk);
        sync[0] = 1'b1;
        watch(0, 1000, 1'b1);
        assert_cnt++; if (acks !== 1 || ss_low !== 330) begin fail_cnt++; $display("FAIL held_high: got ack=%0d ss_low=%0d expected 1/330", acks, ss_low); end
        sync[0] = 1'b0;
        repeat (10) @(negedge clk);
        sync[0] = 1'b1;
        watch(0, 1, 1'b1);
        tot_acks = acks; tot_ss = ss_low;
        sync[0] = 1'b0;
        watch(0, 60, 1'b1);
        tot_acks += acks; tot_ss += ss_low;
        sync[0] = 1'b1;
        watch(0, 1, 1'b1);
        tot_acks += acks; tot_ss += ss_low;
        sync[0] = 1'b0;
        watch(0, 800, 1'b1);
        tot_acks += acks; tot_ss += ss_low;
        assert_cnt++; if (tot_acks !== 1 || tot_ss !== 330) begin fail_cnt++; $display("FAIL retrigger_ignored: got ack=%0d ss_low=%0d expected 1/330", tot_acks, tot_ss); end
    endtask

    task automatic test_reset_abort();
        repeat (10) @(negedge clk);
        sync[0] = 1'b1;
        watch(0, 80, 1'b1);
        rst = 1'b1;
        sync[0] = 1'b0;
        @(negedge clk);
        assert_cnt++; if (ss[0] !== 1'b1 || sclk[0] !== 1'b0 || mosi[0] !== 1'b0) begin fail_cnt++; $display("FAIL abort_lines: got ss=%b sclk=%b mosi=%b expected 1/0/0", ss[0], sclk[0], mosi[0]); end
        assert_cnt++; if (ack[0] !== 1'b0 || rdata0 !== 32'h0) begin fail_cnt++; $display("FAIL abort_outputs: got ack=%b rdata=%h expected 0/0", ack[0], rdata0); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        watch(0, 400, 1'b1);
        assert_cnt++; if (acks !== 0 || ss_low !== 0 || rdata0 !== 32'h0) begin fail_cnt++; $display("FAIL abort_quiet: got ack=%0d ss_low=%0d rdata=%h expected 0/0/0", acks, ss_low, rdata0); end
    endtask

    task automatic test_sync_at_reset();
        rst = 1'b1;
        sync[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        watch(0, 400, 1'b1);
        sync[0] = 1'b0;
        assert_cnt++; if (acks !== 1 || ss_low !== 330) begin fail_cnt++; $display("FAIL sync_at_reset: got ack=%0d ss_low=%0d expected 1/330", acks, ss_low); end
        assert_cnt++; if (rdata0 !== 32'hFFFF_A5A5) begin fail_cnt++; $display("FAIL sync_at_reset_rdata: got %h expected ffffa5a5", rdata0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sample_falling();
        test_idle_levels();
        test_deglitch();
        test_back_to_back();
        test_reset_abort();
        test_sync_at_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter IDLE_VALUE_for_Clk, default 0: o_SPI_Clk level while idle (CPOL).
REQ-002 Parameter IDLE_VALUE_for_MOSI, default 0: o_SPI_MOSI level while o_SPI_SS is high.
REQ-003 Parameter DATA_VALID_at_FALLING, default 0: 0 = sample edge is rising and launch edge is falling; 1 = sample edge is falling and launch edge is rising.
REQ-004 Parameter Tran_width, default 32: bits per transfer, range 1..32.
REQ-005 Parameter DE_GLITCH_Enable, default 0: 1 = MISO passes through a deglitch filter.
REQ-006 Parameter CLK_HALF, default 5: SCLK half-period in c_clk_100m cycles, minimum 2, or minimum 4 when DE_GLITCH_Enable=1.
REQ-007 Clocking: one clock; reset is synchronous and active-high.
REQ-008 c_clk_100m  in  1  system clock; all logic on its rising edge.
REQ-009 i_rst  in  1  synchronous active-high reset.
REQ-010 i_SPI_Send_Sync  in  1  transfer request; a rising edge starts a transfer.
REQ-011 i_SPI_Send_Data  in  Tran_width  transmit word, MSB first.
REQ-012 o_SPI_Send_Over_ack  out  1  one-cycle pulse when a transfer completes.
REQ-013 o_SPI_Receive_Sync  out  1  one-cycle pulse when o_SPI_Receive_Data is updated.
REQ-014 o_SPI_Receive_Data  out  Tran_width  last received word.
REQ-015 o_SPI_Clk  out  1  SPI clock.
REQ-016 o_SPI_SS  out  1  slave select, active low.
REQ-017 o_SPI_MOSI  out  1  serial data out.
REQ-018 i_SPI_MISO  in  1  serial data in; an unconnected input reads as 0.

Function
REQ-019 Start detection: i_SPI_Send_Sync is registered, and start = current value AND NOT previous value; the previous-value register resets to 0.
REQ-020 FSM states are IDLE, LEAD, XFER, TRAIL and GAP; a start is accepted only in IDLE, and a start in any other state is ignored and not queued.
REQ-021 IDLE to LEAD: on an accepted start, latch i_SPI_Send_Data and assert o_SPI_SS low on the next cycle.
REQ-022 LEAD lasts CLK_HALF cycles with o_SPI_Clk at its idle level.
REQ-023 XFER produces exactly 2*Tran_width SCLK edges, one every CLK_HALF cycles, beginning at the end of LEAD; o_SPI_Clk ends at its idle level.
REQ-024 If the first SCLK edge is a sample edge, the MSB is driven on o_SPI_MOSI when o_SPI_SS asserts, each following launch edge shifts out the next bit, and the final launch edge holds the LSB.
REQ-025 If the first SCLK edge is a launch edge, o_SPI_MOSI stays at IDLE_VALUE_for_MOSI during LEAD, the MSB is driven at the first edge, and each later launch edge drives the next bit.
REQ-026 MISO is shifted into the receive register MSB first at each of the Tran_width sample edges.
REQ-027 TRAIL lasts CLK_HALF cycles after the last edge; at its end, on the same cycle:
- o_SPI_SS rises to 1;
- o_SPI_MOSI returns to IDLE_VALUE_for_MOSI;
- o_SPI_Receive_Data is loaded;
- o_SPI_Receive_Sync pulses for one cycle;
- o_SPI_Send_Over_ack pulses for one cycle.
REQ-028 o_SPI_SS is low for exactly (2*Tran_width+2)*CLK_HALF cycles per transfer.
REQ-029 GAP holds o_SPI_SS high for CLK_HALF cycles, then the FSM returns to IDLE.
REQ-030 A request level held high across a completed transfer does not start another transfer; a new rising edge is required.
REQ-031 Deglitch enabled: MISO passes through a 2-FF synchronizer and then a 3-sample majority vote; the sample edge uses the filtered value.
REQ-032 Deglitch disabled: MISO is sampled directly on the sample-edge cycle.
REQ-033 i_SPI_Send_Data changes after the latch point do not affect a transfer in progress.

Reset
REQ-034 While i_rst=1 at a clock edge, the block SHALL force:
- FSM to IDLE;
- o_SPI_Clk to IDLE_VALUE_for_Clk;
- o_SPI_SS to 1;
- o_SPI_MOSI to IDLE_VALUE_for_MOSI;
- both pulse outputs to 0;
- o_SPI_Receive_Data to 0;
- shift registers and counters to 0.
REQ-035 Reset during a transfer aborts it immediately, with no ack pulse and no Receive_Data update.
REQ-036 With i_SPI_Send_Sync high when reset releases, a transfer starts, per REQ-019.

Verification
REQ-037 Default parameters, data 0xFFFFA5A5, MISO looped back to MOSI, rising edge on Sync -> 32 SCLK pulses, MOSI bits 0xFFFFA5A5 MSB first, SS low for 330 cycles, Receive_Data=0xFFFFA5A5, single ack pulse and single Receive_Sync pulse on the same cycle.
REQ-038 DATA_VALID_at_FALLING=1, Tran_width=24, data 0xA5A5A5 latched, MISO=0 -> MOSI driven on rising edges and stable at falling edges, 24 pulses, SS low for 250 cycles, Receive_Data=0x000000.
REQ-039 IDLE_VALUE_for_Clk=1, IDLE_VALUE_for_MOSI=1 -> idle SCLK=1 and MOSI=1, and SCLK returns to 1 after the last edge.
REQ-040 Sync held high for 1000 cycles -> exactly one transfer; a second Sync pulse during XFER is ignored.
REQ-041 Reset asserted mid-XFER -> next cycle SS=1, SCLK at idle, no ack, and Receive_Data unchanged at 0.
REQ-042 DE_GLITCH_Enable=1, a 1-cycle MISO glitch injected mid half-period on constant 0 -> Receive_Data=0.
